// File: rtl/multi_clock_gen.sv
// Multi-channel clock/tick generator: each channel divides clk by a
// runtime divisor and emits a one-cycle tick plus a square or pulse clk_out.
module multi_clock_gen #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       enable,
    input  logic [N_CH*WIDTH-1:0] divisor,
    input  logic [N_CH-1:0]       mode,
    input  logic                  sync_restart,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       clk_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] cnt_nxt;
        logic [WIDTH-1:0] k_s;
        logic [WIDTH-1:0] k_in;
        logic             m_s;
        logic             tick_q;
        logic             tick_nxt;
        logic             clk_q;
        logic             clk_nxt;
        logic             load;

        assign k_in = divisor[i*WIDTH +: WIDTH];

        // Shadow divisor/mode are reloaded on every edge except mid-period
        // counting, so a running period is never shortened or stretched.
        always_comb begin
            cnt_nxt  = cnt;
            tick_nxt = 1'b0;
            clk_nxt  = m_s ? 1'b0 : clk_q;
            load     = 1'b1;
            if (sync_restart) begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
            end else if (enable[i]) begin
                if (k_s == '0) begin
                    cnt_nxt = '0;
                    clk_nxt = 1'b0;
                end else if (cnt >= k_s - ONE) begin
                    // >= guards a count held across a smaller reload
                    cnt_nxt  = '0;
                    tick_nxt = 1'b1;
                    clk_nxt  = m_s | ~clk_q;
                end else begin
                    cnt_nxt = cnt + ONE;
                    load    = 1'b0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                tick_q <= 1'b0;
                clk_q  <= 1'b0;
                k_s    <= k_in;
                m_s    <= mode[i];
            end else begin
                cnt    <= cnt_nxt;
                tick_q <= tick_nxt;
                clk_q  <= clk_nxt;
                if (load) begin
                    k_s <= k_in;
                    m_s <= mode[i];
                end
            end
        end

        assign tick[i]    = tick_q;
        assign clk_out[i] = clk_q;
    end

endmodule
